// File: rtl/micro_bus_responder.sv
// micro_bus_responder
// Memory and peripheral side of the MicroUAZ 8-bit core buses.
// - Instruction side: 256x9 IMEM, read combinationally by the core PC.
//   While the core is held, a fixed NOP word is returned instead.
// - Data side: 252x8 DRAM at 0x00-0xFB, plus four registers:
//   GPIO_OUT (0xFC), GPIO_IN (0xFD), TIMER (0xFE) and TIMER_CTRL (0xFF).
// - Program loader: an IDLE/LOAD/DONE FSM that streams words into IMEM
//   while holding the core.
// Ports:
//   Clk, Rst                  clock, asynchronous active-low reset
//   i_Addres_Instruction_Bus  core PC          -> o_Instruction
//   i_Addres_Data_Bus         data address
//   i_DataOut_Bus, i_RW       write data, 1 = write / 0 = read
//   o_Dato_Bus                combinational read data
//   i_Load_*                  loader handshake inputs
//   o_Load_Ready              loader may transfer
//   o_Core_Hold               core must be held in reset
//   i_Gpio                    asynchronous inputs
//   o_Gpio                    registered outputs
module micro_bus_responder #(
  parameter int unsigned TIMER_PRESCALE = 4,
  parameter logic [8:0]  NOP_WORD       = 9'b111_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] i_Addres_Instruction_Bus,
  output logic [8:0] o_Instruction,
  input  logic [7:0] i_Addres_Data_Bus,
  input  logic [7:0] i_DataOut_Bus,
  input  logic       i_RW,
  output logic [7:0] o_Dato_Bus,
  input  logic       i_Load_Start,
  input  logic       i_Load_Valid,
  input  logic [8:0] i_Load_Data,
  input  logic       i_Load_Last,
  output logic       o_Load_Ready,
  output logic       o_Core_Hold,
  input  logic [7:0] i_Gpio,
  output logic [7:0] o_Gpio
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] ADDR_GPIO_OUT  = 8'hFC;
  localparam logic [7:0] ADDR_GPIO_IN   = 8'hFD;
  localparam logic [7:0] ADDR_TIMER     = 8'hFE;
  localparam logic [7:0] ADDR_TIMER_CTL = 8'hFF;

  localparam logic [7:0] PRESCALE_LAST = 8'(TIMER_PRESCALE - 1);

  logic [8:0] imem_r [0:255];
  logic [7:0] dram_r [0:251];

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] load_cnt_r;
  logic       load_xfer_s;
  logic       wr_en_s;
  logic [7:0] gpio_sync1_r;
  logic [7:0] gpio_sync2_r;
  logic [7:0] timer_r;
  logic [7:0] presc_r;
  logic       timer_en_r;
  logic       timer_wr_s;

  // Core writes are dropped while the core is held (covers load collisions).
  assign wr_en_s     = i_RW & ~o_Core_Hold;
  assign timer_wr_s  = wr_en_s & (i_Addres_Data_Bus == ADDR_TIMER);
  // Ready is only ever high in LOAD, so it alone qualifies a transfer.
  assign load_xfer_s = i_Load_Valid & o_Load_Ready;

  // Loader FSM next-state: a transfer at counter 255 also ends the load.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_Load_Start) state_nxt_s = ST_LOAD;
        else              state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_xfer_s && (i_Load_Last || (load_cnt_r == 8'hFF))) state_nxt_s = ST_DONE;
        else                                                       state_nxt_s = ST_LOAD;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Loader state plus registered hold/ready decoded from the next state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r      <= ST_IDLE;
      o_Core_Hold  <= 1'b0;
      o_Load_Ready <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      o_Core_Hold  <= (state_nxt_s != ST_IDLE);
      o_Load_Ready <= (state_nxt_s == ST_LOAD);
    end
  end

  // Load address counter: cleared on start, advanced per transfer.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      load_cnt_r <= 8'd0;
    end else if ((state_r == ST_IDLE) && i_Load_Start) begin
      load_cnt_r <= 8'd0;
    end else if (load_xfer_s) begin
      load_cnt_r <= load_cnt_r + 8'd1;
    end
  end

  // IMEM write port, driven only by the loader; contents survive reset.
  always_ff @(posedge Clk) begin
    if (load_xfer_s) imem_r[load_cnt_r] <= i_Load_Data;
  end

  // DRAM write port; contents survive reset.
  always_ff @(posedge Clk) begin
    if (wr_en_s && (i_Addres_Data_Bus < ADDR_GPIO_OUT)) dram_r[i_Addres_Data_Bus] <= i_DataOut_Bus;
  end

  // GPIO output register and two-flop input synchronizer.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      o_Gpio       <= 8'h00;
      gpio_sync1_r <= 8'h00;
      gpio_sync2_r <= 8'h00;
    end else begin
      if (wr_en_s && (i_Addres_Data_Bus == ADDR_GPIO_OUT)) o_Gpio <= i_DataOut_Bus;
      gpio_sync1_r <= i_Gpio;
      gpio_sync2_r <= gpio_sync1_r;
    end
  end

  // Timer: any write restarts count and prescaler, taking priority over
  // an increment in the same cycle; disabling freezes both.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      timer_r <= 8'h00;
      presc_r <= 8'h00;
    end else if (timer_wr_s) begin
      timer_r <= 8'h00;
      presc_r <= 8'h00;
    end else if (timer_en_r) begin
      if (presc_r == PRESCALE_LAST) begin
        presc_r <= 8'h00;
        timer_r <= timer_r + 8'd1;
      end else begin
        presc_r <= presc_r + 8'd1;
      end
    end
  end

  // Timer enable bit in TIMER_CTRL.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      timer_en_r <= 1'b0;
    end else if (wr_en_s && (i_Addres_Data_Bus == ADDR_TIMER_CTL)) begin
      timer_en_r <= i_DataOut_Bus[0];
    end
  end

  // Combinational data read mux.
  always_comb begin
    o_Dato_Bus = 8'h00;
    if (i_Addres_Data_Bus < ADDR_GPIO_OUT) begin
      o_Dato_Bus = dram_r[i_Addres_Data_Bus];
    end else begin
      case (i_Addres_Data_Bus)
        ADDR_GPIO_OUT:  o_Dato_Bus = o_Gpio;
        ADDR_GPIO_IN:   o_Dato_Bus = gpio_sync2_r;
        ADDR_TIMER:     o_Dato_Bus = timer_r;
        ADDR_TIMER_CTL: o_Dato_Bus = {7'b000_0000, timer_en_r};
        default:        o_Dato_Bus = 8'h00;
      endcase
    end
  end

  // Instruction fetch; the held core sees NOPs.
  always_comb begin
    o_Instruction = NOP_WORD;
    if (o_Core_Hold) o_Instruction = NOP_WORD;
    else             o_Instruction = imem_r[i_Addres_Instruction_Bus];
  end

endmodule

// File: tb/tb_micro_bus_responder.sv
module tb_micro_bus_responder;
  localparam int         P   = 4;
  localparam logic [8:0] NOP = 9'b111_000_000;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] i_Addres_Instruction_Bus;
  logic [8:0] o_Instruction;
  logic [7:0] i_Addres_Data_Bus;
  logic [7:0] i_DataOut_Bus;
  logic       i_RW;
  logic [7:0] o_Dato_Bus;
  logic       i_Load_Start;
  logic       i_Load_Valid;
  logic [8:0] i_Load_Data;
  logic       i_Load_Last;
  logic       o_Load_Ready;
  logic       o_Core_Hold;
  logic [7:0] i_Gpio;
  logic [7:0] o_Gpio;

  micro_bus_responder #(.TIMER_PRESCALE(P), .NOP_WORD(NOP)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_Addres_Instruction_Bus(i_Addres_Instruction_Bus), .o_Instruction(o_Instruction),
    .i_Addres_Data_Bus(i_Addres_Data_Bus), .i_DataOut_Bus(i_DataOut_Bus), .i_RW(i_RW),
    .o_Dato_Bus(o_Dato_Bus), .i_Load_Start(i_Load_Start), .i_Load_Valid(i_Load_Valid),
    .i_Load_Data(i_Load_Data), .i_Load_Last(i_Load_Last), .o_Load_Ready(o_Load_Ready),
    .o_Core_Hold(o_Core_Hold), .i_Gpio(i_Gpio), .o_Gpio(o_Gpio)
  );

  always #5 Clk = ~Clk;

  int total  = 0;
  int passed = 0;

  // Reference model: loader phase 0 idle / 1 loading / 2 done; the timer is
  // kept as a count of enabled cycles since the last clear.
  int         m_phase;
  int         m_cnt;
  int         m_cyc;
  bit         m_en;
  logic [7:0] m_gpo, m_gprev, m_gvis;
  logic [7:0] m_dram [int];
  logic [8:0] m_imem [int];

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_cyc = 0; m_en = 1'b0;
    m_gpo = 8'h00; m_gprev = 8'h00; m_gvis = 8'h00;
  endtask

  function automatic logic [7:0] m_timer();
    return 8'((m_cyc / P) % 256);
  endfunction

  task automatic model_edge();
    bit wr;
    int a;
    wr = i_RW && (m_phase == 0);
    a  = int'(i_Addres_Data_Bus);
    if (wr && a == 254) m_cyc = 0;
    else if (m_en)      m_cyc = (m_cyc + 1) % (256 * P);
    if (wr && a == 255) m_en = i_DataOut_Bus[0];
    if (wr && a < 252)  m_dram[a] = i_DataOut_Bus;
    if (wr && a == 252) m_gpo = i_DataOut_Bus;
    m_gvis  = m_gprev;
    m_gprev = i_Gpio;
    case (m_phase)
      0: if (i_Load_Start) begin m_phase = 1; m_cnt = 0; end
      1: if (i_Load_Valid) begin
           m_imem[m_cnt] = i_Load_Data;
           if (i_Load_Last || m_cnt == 255) m_phase = 2;
           m_cnt = m_cnt + 1;
         end
      default: m_phase = 0;
    endcase
  endtask

  // Advance one clock: update the model from the inputs the DUT samples,
  // then return 1 time unit after the edge.
  task automatic edge_step();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int a;
    a = int'(i_Addres_Data_Bus);
    check({tag, ".hold"},  32'(o_Core_Hold),  32'(m_phase != 0));
    check({tag, ".ready"}, 32'(o_Load_Ready), 32'(m_phase == 1));
    check({tag, ".gpio"},  32'(o_Gpio),       32'(m_gpo));
    if (m_phase != 0) check({tag, ".instr"}, 32'(o_Instruction), 32'(NOP));
    else if (m_imem.exists(int'(i_Addres_Instruction_Bus)))
      check({tag, ".instr"}, 32'(o_Instruction), 32'(m_imem[int'(i_Addres_Instruction_Bus)]));
    if (a < 252) begin
      if (m_dram.exists(a)) check({tag, ".dram"}, 32'(o_Dato_Bus), 32'(m_dram[a]));
    end else if (a == 252) check({tag, ".rd_gpo"},   32'(o_Dato_Bus), 32'(m_gpo));
    else if (a == 253)     check({tag, ".rd_gpi"},   32'(o_Dato_Bus), 32'(m_gvis));
    else if (a == 254)     check({tag, ".rd_timer"}, 32'(o_Dato_Bus), 32'(m_timer()));
    else                   check({tag, ".rd_ctrl"},  32'(o_Dato_Bus), {31'd0, m_en});
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    i_RW = 1'b1; i_Addres_Data_Bus = addr; i_DataOut_Bus = data;
    edge_step();
    i_RW = 1'b0;
    #1;
  endtask

  logic [8:0] words [0:2];

  initial begin
    words[0] = 9'b000_000_111; words[1] = 9'b000_001_110; words[2] = 9'b001_010_000;
    Rst = 1'b0; i_RW = 1'b0; i_Addres_Data_Bus = 8'hFE; i_DataOut_Bus = 8'h00;
    i_Addres_Instruction_Bus = 8'h00; i_Load_Start = 1'b0; i_Load_Valid = 1'b0;
    i_Load_Data = 9'h000; i_Load_Last = 1'b0; i_Gpio = 8'h00;
    model_reset();
    #1 Rst = 1'b1;
    #1;
    check("rst.gpio",  32'(o_Gpio), 32'h00);
    check("rst.hold",  32'(o_Core_Hold), 32'h0);
    check("rst.ready", 32'(o_Load_Ready), 32'h0);
    check("rst.timer", 32'(o_Dato_Bus), 32'h00);

    // DRAM and GPIO_OUT
    bus_write(8'h10, 8'h0A);
    i_Addres_Data_Bus = 8'h10; #1;
    check("dram.rd", 32'(o_Dato_Bus), 32'h0A);
    bus_write(8'hFC, 8'h55);
    check("gpio.out", 32'(o_Gpio), 32'h55);
    check_all("dir1");

    // Program load of three words; a data write during the load is dropped
    i_Load_Start = 1'b1;
    edge_step();
    i_Load_Start = 1'b0; #1;
    check("load.hold", 32'(o_Core_Hold), 32'h1);
    check("load.ready", 32'(o_Load_Ready), 32'h1);
    check("load.nop", 32'(o_Instruction), 32'(NOP));
    for (int i = 0; i < 3; i++) begin
      i_Load_Valid = 1'b1; i_Load_Data = words[i]; i_Load_Last = (i == 2);
      i_RW = (i == 1); i_Addres_Data_Bus = 8'h10; i_DataOut_Bus = 8'hEE;
      edge_step();
    end
    i_Load_Valid = 1'b0; i_Load_Last = 1'b0; i_RW = 1'b0; #1;
    check("done.hold", 32'(o_Core_Hold), 32'h1);
    check("done.ready", 32'(o_Load_Ready), 32'h0);
    check("done.nop", 32'(o_Instruction), 32'(NOP));
    edge_step(); #1;
    check("idle.hold", 32'(o_Core_Hold), 32'h0);
    check("drop.dram", 32'(o_Dato_Bus), 32'h0A);
    i_Addres_Instruction_Bus = 8'd0; #1; check("fetch0", 32'(o_Instruction), 32'h007);
    i_Addres_Instruction_Bus = 8'd1; #1; check("fetch1", 32'(o_Instruction), 32'h00E);
    i_Addres_Instruction_Bus = 8'd2; #1; check("fetch2", 32'(o_Instruction), 32'h050);

    // GPIO_IN synchronizer latency and read-only behaviour
    i_Gpio = 8'h3C; i_Addres_Data_Bus = 8'hFD;
    edge_step(); check("gpi.edge1", 32'(o_Dato_Bus), 32'h00);
    edge_step(); check("gpi.edge2", 32'(o_Dato_Bus), 32'h3C);
    bus_write(8'hFD, 8'hFF);
    i_Addres_Data_Bus = 8'hFD; #1;
    check("gpi.ro", 32'(o_Dato_Bus), 32'h3C);

    // Timer
    bus_write(8'hFF, 8'h01);
    i_Addres_Data_Bus = 8'hFF; #1; check("ctrl.rd", 32'(o_Dato_Bus), 32'h01);
    i_Addres_Data_Bus = 8'hFE;
    repeat (40) edge_step();
    check("timer.40", 32'(o_Dato_Bus), 32'h0A);
    while ((m_cyc % P) != P - 1) edge_step();
    bus_write(8'hFE, 8'h77);
    i_Addres_Data_Bus = 8'hFE; #1;
    check("timer.clr_wrap", 32'(o_Dato_Bus), 32'h00);
    repeat (255 * P) edge_step();
    check("timer.ff", 32'(o_Dato_Bus), 32'hFF);
    repeat (P) edge_step();
    check("timer.wrap0", 32'(o_Dato_Bus), 32'h00);
    repeat (255 * P) edge_step();
    check("timer.ff2", 32'(o_Dato_Bus), 32'hFF);
    bus_write(8'hFF, 8'h00);
    i_Addres_Data_Bus = 8'hFE;
    repeat (10) edge_step();
    check_all("frozen");

    // Randomized bus traffic against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       i_Addres_Data_Bus = 8'($urandom_range(0, 15));
        1:       i_Addres_Data_Bus = 8'($urandom_range(252, 255));
        default: i_Addres_Data_Bus = 8'($urandom_range(0, 251));
      endcase
      i_RW = 1'($urandom_range(0, 1));
      i_DataOut_Bus = 8'($urandom);
      if ($urandom_range(0, 3) == 0) i_Gpio = 8'($urandom);
      i_Addres_Instruction_Bus = 8'($urandom_range(0, 2));
      #1;
      check_all("rand");
      edge_step();
    end
    i_RW = 1'b0;

    // Reset in the middle of a load
    i_Load_Start = 1'b1; edge_step(); i_Load_Start = 1'b0;
    i_Load_Valid = 1'b1; i_Load_Data = 9'h1A5; edge_step();
    i_Load_Data = 9'h04B; edge_step();
    i_Load_Valid = 1'b0; #1;
    check("midload.hold", 32'(o_Core_Hold), 32'h1);
    Rst = 1'b0; model_reset(); #1;
    check("rstload.hold", 32'(o_Core_Hold), 32'h0);
    check("rstload.ready", 32'(o_Load_Ready), 32'h0);
    check("rstload.gpio", 32'(o_Gpio), 32'h00);
    Rst = 1'b1; #1;
    edge_step();
    i_Addres_Instruction_Bus = 8'd0; #1; check("keep0", 32'(o_Instruction), 32'h1A5);
    i_Addres_Instruction_Bus = 8'd1; #1; check("keep1", 32'(o_Instruction), 32'h04B);
    i_Load_Start = 1'b1; edge_step(); i_Load_Start = 1'b0;
    i_Load_Valid = 1'b1; i_Load_Last = 1'b1; i_Load_Data = 9'h0C3; edge_step();
    i_Load_Valid = 1'b0; i_Load_Last = 1'b0;
    edge_step();
    i_Addres_Instruction_Bus = 8'd0; #1; check("reload0", 32'(o_Instruction), 32'h0C3);
    i_Addres_Instruction_Bus = 8'd1; #1; check("reload1", 32'(o_Instruction), 32'h04B);
    check_all("end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
